// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit and its md timer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    SEQ     = 2'd0,
    HANDLER = 2'd1,
    EPC     = 2'd2
  } pc_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Exception handler entry; the PC mux selects it when PC_sel is HANDLER.
  localparam logic [31:0] EXC_VEC = 32'h0000_4180;

endpackage

// File: rtl/md_timer.sv
// Multi-cycle multiply/divide occupancy timer: busy for N cycles after an accepted start.
module md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e             state_q, state_d;
  logic [CntW-1:0]       md_cnt_q, md_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // A start seen while already busy is dropped; the decoder should never issue one.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          md_cnt_d = div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q - CntW'(1);
        if (md_cnt_q == CntW'(1)) begin
          state_d = MD_IDLE;
        end
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY) | start;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: stage enables/flushes, PC select, exception request,
// md busy tracking and saturating stall/exception counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_hazard,
  input  logic             D_md_use,
  input  logic             E_md_start,
  input  logic             E_md_div,
  input  logic             M_bus_wait,
  input  logic             M_exc,
  input  logic             D_eret,
  input  logic             D_nullify,
  output logic             PC_en,
  output logic [1:0]       PC_sel,
  output logic             F2D_en,
  output logic             D2E_en,
  output logic             E2M_en,
  output logic             M2W_en,
  output logic             F2D_flush,
  output logic             D2E_flush,
  output logic             req,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [15:0]      exc_cnt
);

  logic             md_start;
  logic             stall_cycle;
  logic             exc_cycle;
  pc_sel_e          pc_sel;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [15:0]      exc_cnt_q;

  // E2M_en is low only in FREEZE and req only in EXC, so this equals E_md_start & E2M_en & ~req
  // without routing the start back through the priority logic that consumes md_busy.
  assign md_start = E_md_start & ~M_bus_wait & ~M_exc;

  md_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .div   (E_md_div),
    .busy  (md_busy)
  );

  always_comb begin
    PC_en       = 1'b1;
    pc_sel      = SEQ;
    F2D_en      = 1'b1;
    D2E_en      = 1'b1;
    E2M_en      = 1'b1;
    M2W_en      = 1'b1;
    F2D_flush   = 1'b0;
    D2E_flush   = 1'b0;
    req         = 1'b0;
    stall_cycle = 1'b0;
    exc_cycle   = 1'b0;
    if (M_exc) begin
      req       = 1'b1;
      pc_sel    = HANDLER;
      exc_cycle = 1'b1;
    end else if (M_bus_wait) begin
      PC_en       = 1'b0;
      F2D_en      = 1'b0;
      D2E_en      = 1'b0;
      E2M_en      = 1'b0;
      M2W_en      = 1'b0;
      stall_cycle = 1'b1;
    end else if (D_hazard | (D_md_use & md_busy)) begin
      PC_en       = 1'b0;
      F2D_en      = 1'b0;
      D2E_flush   = 1'b1;
      stall_cycle = 1'b1;
    end else begin
      if (D_eret) begin
        pc_sel = EPC;
      end
      F2D_flush = D_eret | D_nullify;
    end
  end

  assign PC_sel = pc_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      exc_cnt_q   <= '0;
    end else begin
      if (stall_cycle && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (exc_cycle && (exc_cnt_q != '1)) begin
        exc_cnt_q <= exc_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign exc_cnt   = exc_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;
  localparam int CW = 8;
  localparam int StallMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          D_hazard, D_md_use, E_md_start, E_md_div;
  logic          M_bus_wait, M_exc, D_eret, D_nullify;
  logic          PC_en, F2D_en, D2E_en, E2M_en, M2W_en, F2D_flush, D2E_flush, req, md_busy;
  logic [1:0]    PC_sel;
  logic [CW-1:0] stall_cnt;
  logic [15:0]   exc_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .D_hazard   (D_hazard),
    .D_md_use   (D_md_use),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .M_bus_wait (M_bus_wait),
    .M_exc      (M_exc),
    .D_eret     (D_eret),
    .D_nullify  (D_nullify),
    .PC_en      (PC_en),
    .PC_sel     (PC_sel),
    .F2D_en     (F2D_en),
    .D2E_en     (D2E_en),
    .E2M_en     (E2M_en),
    .M2W_en     (M2W_en),
    .F2D_flush  (F2D_flush),
    .D2E_flush  (D2E_flush),
    .req        (req),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt),
    .exc_cnt    (exc_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  // Model: remaining busy cycles of the HI/LO unit after the current one, plus counters.
  int m_rem = 0;
  int m_stall = 0;
  int m_exc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A start needs E2M enabled (not frozen) and no exception request.
  function automatic bit mdl_accept();
    return E_md_start && !M_bus_wait && !M_exc;
  endfunction

  function automatic bit mdl_busy();
    return (m_rem > 0) || mdl_accept();
  endfunction

  function automatic bit mdl_stall();
    return !M_exc && (M_bus_wait || D_hazard || (D_md_use && mdl_busy()));
  endfunction

  // {PC_en, PC_sel, F2D_en, D2E_en, E2M_en, M2W_en, F2D_flush, D2E_flush, req}
  function automatic logic [9:0] mdl_ctrl();
    if (M_exc) return {1'b1, 2'd1, 4'b1111, 1'b0, 1'b0, 1'b1};
    if (M_bus_wait) return 10'd0;
    if (D_hazard || (D_md_use && mdl_busy())) return {1'b0, 2'd0, 4'b0111, 1'b0, 1'b1, 1'b0};
    return {1'b1, (D_eret ? 2'd2 : 2'd0), 4'b1111, (D_eret | D_nullify), 1'b0, 1'b0};
  endfunction

  task automatic clear_inputs();
    D_hazard = 0; D_md_use = 0; E_md_start = 0; E_md_div = 0;
    M_bus_wait = 0; M_exc = 0; D_eret = 0; D_nullify = 0;
  endtask

  // Compare every output against the model, then advance one clock and update the model.
  task automatic tick(input string tag);
    bit acc, stl, exc;
    check_eq({tag, ".ctrl"},
             {22'd0, PC_en, PC_sel, F2D_en, D2E_en, E2M_en, M2W_en, F2D_flush, D2E_flush, req},
             {22'd0, mdl_ctrl()});
    check_eq({tag, ".busy"}, {31'd0, md_busy}, {31'd0, mdl_busy()});
    check_eq({tag, ".stall_cnt"}, 32'(stall_cnt), m_stall);
    check_eq({tag, ".exc_cnt"}, 32'(exc_cnt), m_exc);
    acc = mdl_accept();
    stl = mdl_stall();
    exc = M_exc;
    @(posedge clk);
    if (m_rem > 0) m_rem--;
    else if (acc) m_rem = E_md_div ? DC : MC;
    if (stl && m_stall < StallMax) m_stall++;
    if (exc && m_exc < 65535) m_exc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    #2;
    m_rem = 0; m_stall = 0; m_exc = 0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  int hi;

  initial begin
    clear_inputs();
    reset = 1;
    #1;
    do_reset();
    check_eq("reset.busy", {31'd0, md_busy}, 0);
    check_eq("reset.stall_cnt", 32'(stall_cnt), 0);
    check_eq("reset.exc_cnt", 32'(exc_cnt), 0);

    // Mult start with a dependent md op waiting in D.
    E_md_start = 1; D_md_use = 1;
    for (int c = 0; c <= 6; c++) begin
      #3;
      check_eq($sformatf("mult.f2d_en%0d", c), {31'd0, F2D_en}, (c < 6) ? 0 : 1);
      check_eq($sformatf("mult.d2e_flush%0d", c), {31'd0, D2E_flush}, (c < 6) ? 1 : 0);
      tick("mult");
      E_md_start = 0;
    end
    check_eq("mult.stall_cnt", 32'(stall_cnt), 6);
    clear_inputs();

    // Div start held while the bus is frozen.
    do_reset();
    E_md_start = 1; E_md_div = 1; M_bus_wait = 1;
    for (int c = 0; c < 3; c++) begin
      #3;
      check_eq("divfrz.busy_frozen", {31'd0, md_busy}, 0);
      tick("divfrz");
    end
    M_bus_wait = 0;
    hi = 0;
    for (int c = 0; c < 14; c++) begin
      #3;
      if (md_busy) hi++;
      tick("divrel");
      E_md_start = 0; E_md_div = 0;
    end
    check_eq("divfrz.busy_cycles", hi, 11);

    // Exception and freeze in the same cycle.
    do_reset();
    M_exc = 1; M_bus_wait = 1;
    #3;
    check_eq("excfrz.req", {31'd0, req}, 1);
    check_eq("excfrz.pc_sel", {30'd0, PC_sel}, 1);
    check_eq("excfrz.pc_en", {31'd0, PC_en}, 1);
    check_eq("excfrz.ens", {28'd0, F2D_en, D2E_en, E2M_en, M2W_en}, 4'hf);
    check_eq("excfrz.exc_cnt0", 32'(exc_cnt), 0);
    tick("excfrz");
    clear_inputs();
    #3;
    check_eq("excfrz.exc_cnt1", 32'(exc_cnt), 1);

    // Hazard masks eret, eret takes effect once the hazard clears.
    D_eret = 1; D_hazard = 1;
    #3;
    check_eq("eret.haz_pc_sel", {30'd0, PC_sel}, 0);
    check_eq("eret.haz_flush", {31'd0, F2D_flush}, 0);
    tick("eret");
    D_hazard = 0;
    #3;
    check_eq("eret.run_pc_sel", {30'd0, PC_sel}, 2);
    check_eq("eret.run_flush", {31'd0, F2D_flush}, 1);
    tick("eret2");
    clear_inputs();

    // Nullify on its own.
    D_nullify = 1;
    #3;
    check_eq("null.f2d_flush", {31'd0, F2D_flush}, 1);
    check_eq("null.pc_en", {31'd0, PC_en}, 1);
    check_eq("null.d2e_flush", {31'd0, D2E_flush}, 0);
    tick("null");
    clear_inputs();

    // Reset arriving in cycle 4 of a div, with counters made nonzero first.
    do_reset();
    E_md_start = 1; E_md_div = 1;
    for (int c = 0; c < 4; c++) begin
      #3;
      tick("rstdiv");
      clear_inputs();
      if (c == 0) D_hazard = 1;
      if (c == 1) M_exc = 1;
    end
    #1;
    check_eq("rstdiv.busy_before", {31'd0, md_busy}, 1);
    check_eq("rstdiv.stall_before", 32'(stall_cnt), 1);
    reset = 0;
    #1;
    check_eq("rstdiv.busy_async", {31'd0, md_busy}, 0);
    check_eq("rstdiv.stall_async", 32'(stall_cnt), 0);
    check_eq("rstdiv.exc_async", 32'(exc_cnt), 0);
    m_rem = 0; m_stall = 0; m_exc = 0;
    @(posedge clk);
    #1;
    reset = 1;
    D_md_use = 1;
    #3;
    check_eq("rstdiv.f2d_en", {31'd0, F2D_en}, 1);
    check_eq("rstdiv.d2e_flush", {31'd0, D2E_flush}, 0);
    tick("rstdiv_post");
    clear_inputs();

    // Long freeze drives stall_cnt into saturation.
    M_bus_wait = 1;
    for (int c = 0; c < StallMax + 5; c++) begin
      #3;
      tick("sat");
    end
    check_eq("sat.stall_cnt", 32'(stall_cnt), StallMax);
    clear_inputs();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      M_exc      = ($urandom_range(15) == 0);
      M_bus_wait = ($urandom_range(7) == 0);
      D_hazard   = ($urandom_range(5) == 0);
      D_md_use   = ($urandom_range(2) == 0);
      E_md_start = ($urandom_range(5) == 0);
      E_md_div   = $urandom_range(1);
      D_eret     = ($urandom_range(7) == 0);
      D_nullify  = ($urandom_range(7) == 0);
      #3;
      tick("rand");
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control unit for the five-stage MIPS core. It produces the enable and flush strobes for the F2D, D2E, E2M and M2W stage registers, the PC update and select lines, and the global exception `req`. It owns the multi-cycle multiply/divide busy timer and two saturating performance counters. It sits beside the hazard decoder and CP0 and arbitrates between their requests with a fixed priority.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu start.
- `CNT_W`, default 32: width of `stall_cnt`.

Ports:
- `clk` in 1: rising-edge clock; the block uses this single clock.
- `reset` in 1: asynchronous, active-low.
- `D_hazard` in 1: data hazard on the D-stage instruction.
- `D_md_use` in 1: D-stage instruction is a md op or mfhi/mflo/mthi/mtlo.
- `E_md_start` in 1: E-stage instruction starts mult/div.
- `E_md_div` in 1: qualifies `E_md_start`. 1 = div, 0 = mult.
- `M_bus_wait` in 1: data bus not ready; the whole pipe must freeze.
- `M_exc` in 1: CP0 accepts an exception or interrupt at M this cycle.
- `D_eret` in 1: D-stage instruction is eret.
- `D_nullify` in 1: D-stage branch-likely not taken; discard the fetched delay slot.
- `PC_en` out 1: PC register write enable.
- `PC_sel` out 2: next-PC select. 0 = sequential/branch, 1 = handler 32'h00004180, 2 = EPC.
- `F2D_en`, `D2E_en`, `E2M_en`, `M2W_en` out 1 each: stage register enables.
- `F2D_flush` out 1: clears the F2D instruction while keeping PC and delay-slot flag.
- `D2E_flush` out 1: inserts a bubble into D2E.
- `req` out 1: exception flush to all stage registers.
- `md_busy` out 1: the HI/LO unit is occupied.
- `stall_cnt` out CNT_W: count of stalled or frozen cycles.
- `exc_cnt` out 16: count of `req` cycles.

## Operation
- Control outputs are combinational from the inputs and the md timer state. The counters and timer are the only flops.
- Case priority is evaluated each cycle, highest first:
  1. **EXC**, when `M_exc`=1:
     - `req`=1, `PC_en`=1, `PC_sel`=1.
     - All `*_en`=1; `F2D_flush`=`D2E_flush`=0.
     - `D_eret` and `D_nullify` are ignored.
  2. **FREEZE**, when `M_bus_wait`=1:
     - All `*_en`=0, `PC_en`=0, all flushes 0, `req`=0.
  3. **STALL_D**, when `D_hazard` | (`D_md_use` & `md_busy`):
     - `PC_en`=`F2D_en`=0.
     - `D2E_en`=1, `D2E_flush`=1.
     - `E2M_en`=`M2W_en`=1.
     - `D_eret` and `D_nullify` are ignored.
  4. **RUN**: all enables are 1.
     - `D_eret` sets `PC_sel`=2 and `F2D_flush`=1.
     - `D_nullify` sets `F2D_flush`=1.
     - `D_eret` and `D_nullify` together: `PC_sel`=2, `F2D_flush`=1.
- The md timer has two states, MD_IDLE and MD_BUSY, plus a counter `md_cnt`.
  - A start is accepted when `E_md_start` & `E2M_en` & ~`req`. A start during FREEZE or EXC is not accepted.
  - On an accepted start in MD_IDLE, `md_cnt` loads `E_md_div ? DIV_CYCLES : MULT_CYCLES` and the state goes to MD_BUSY.
  - In MD_BUSY, `md_cnt` decrements every cycle, independent of FREEZE and `req`. When `md_cnt`==1 the state returns to MD_IDLE.
  - `md_busy` = (state==MD_BUSY) | accepted start this cycle.
  - A start in MD_BUSY cannot legally occur, because the decoder stalls md ops via `D_md_use`. If it does occur anyway, it is ignored.
- `stall_cnt` increments in FREEZE or STALL_D cycles and saturates at all-ones.
- `exc_cnt` increments in EXC cycles and saturates at 16'hFFFF.

## Timing
- Zero-latency control path: strobes are valid in the same cycle as their inputs.
- Start accepted in cycle t: `md_busy`=1 in cycles t through t+N, and 0 in cycle t+N+1 (N = MULT_CYCLES or DIV_CYCLES).
- Reset (`reset`=0) takes effect immediately without a clock:
  - state = MD_IDLE, `md_cnt`=0, `md_busy`=0.
  - `stall_cnt`=0, `exc_cnt`=0.
  - Combinational strobes keep following their input rules.
- Reset during MD_BUSY aborts the operation; `md_busy` drops immediately.
- `M_exc` together with `M_bus_wait`: EXC wins. The exception flush proceeds and the freeze is dropped for that cycle.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - PC_SEL codes: SEQ=0, HANDLER=1, EPC=2.
  - The md state enum.
  - `EXC_VEC` = 32'h00004180, which the PC mux also uses.
- One sub-module, `md_timer`: the timer state machine and counter. Its ports are clk, reset, start, div, busy.

## Test plan
- **Mult stall:** `E_md_start`=1, `E_md_div`=0 at cycle 0; `D_md_use` held at 1.
  - Required: `F2D_en`=0 and `D2E_flush`=1 in cycles 0–5; `F2D_en`=1 in cycle 6; `stall_cnt`=6.
- **Div while frozen:** div start with `M_bus_wait`=1 for 3 cycles, then 0.
  - Required: no accepted start while frozen; `md_busy` is high for 11 cycles from release.
- **Exception beats freeze:** `M_exc`=1 and `M_bus_wait`=1 in the same cycle.
  - Required: `req`=1, `PC_sel`=1, `PC_en`=1, all `*_en`=1; `exc_cnt` goes 0→1.
- **Hazard masks eret:** `D_eret`=1 with `D_hazard`=1.
  - Required: `PC_sel`=0, `F2D_flush`=0.
  - Next cycle, with the hazard cleared: `PC_sel`=2, `F2D_flush`=1.
- **Nullify in RUN:** `D_nullify`=1 with no other inputs active.
  - Required: `F2D_flush`=1, `PC_en`=1, `D2E_flush`=0.
- **Reset mid-div:** `reset`=0 at cycle 4 of a div.
  - Required: `md_busy`=0 and counters 0 without waiting for a clock edge; after release, `D_md_use` causes no stall.
